sbqm_teller_caller: RTL
=======================

SBQM_TELLER_CALLER -- requirements
Module: sbqm_teller_caller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: PULSE_CYCLES, default 2, width in clk cycles of the downSignal low pulse and of the following high gap (legal 1..15).
REQ-003 Parameter: TIMEOUT_CYCLES, default 64, pending-request lifetime while the queue is empty (used only under the Configuration macro).
REQ-004 Ports SHALL be, in this order:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- tellerReady  in  4  level per teller; a 0->1 transition is a "call next customer" request.
- Tcount  in  2  highest active teller index; teller i is eligible only when i <= Tcount.
- emptyFlag  in  1  queue-empty flag from the queue manager.
- downSignal  out  1  active-low departure pulse to the queue manager (idles 1).
- servingTeller  out  2  index of the teller most recently granted.
- ticketNum  out  3  running count of granted calls, modulo 8.
- callValid  out  1  one-cycle pulse; servingTeller and ticketNum are updated in the same cycle.
- busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-005 Edge detection: the block SHALL register tellerReady once per cycle; rise[i] = tellerReady[i] & ~prev[i].
REQ-006 A rise on an eligible teller SHALL set pending[i] on that clock edge; a rise on an ineligible teller (i > Tcount) SHALL be ignored.
REQ-007 Lowering Tcount SHALL clear pending bits of tellers that become ineligible on the next edge.
REQ-008 FSM states SHALL be IDLE, CALL and GAP.
REQ-009 IDLE->CALL SHALL occur when any pending bit is set and emptyFlag==0; otherwise the FSM SHALL remain in IDLE and hold pending bits.
REQ-010 On IDLE->CALL, the grant SHALL be round-robin: search starts at lastGrant+1 mod 4, and the lowest index wins after reset; the granted pending bit SHALL be cleared on that edge.
REQ-011 In CALL, downSignal SHALL be 0 for exactly PULSE_CYCLES cycles, then the FSM SHALL go to GAP.
REQ-012 On CALL->GAP, callValid SHALL pulse for 1 cycle, servingTeller SHALL take the grant index, and ticketNum SHALL increment (7 wraps to 0).
REQ-013 In GAP, downSignal SHALL be 1 for exactly PULSE_CYCLES cycles, then the FSM SHALL return to IDLE. Back-to-back calls therefore give a period of 2*PULSE_CYCLES+1 cycles.
REQ-014 A rise on the teller currently in CALL or GAP SHALL set a new pending bit for a later call; a duplicate rise while that teller is already pending SHALL be absorbed.
REQ-015 A rise and a clear on the same pending bit in the same cycle: the rise SHALL win.
REQ-016 emptyFlag SHALL be sampled only in IDLE; a call in progress SHALL always complete.
REQ-017 Minimum latency SHALL be: rise at edge N, downSignal low from edge N+1.

Reset
REQ-018 While reset=1 at a clock edge, the block SHALL set: FSM=IDLE, pending=0, prev=0, lastGrant=3, downSignal=1, servingTeller=0, ticketNum=0, callValid=0, busy=0.
REQ-019 Reset asserted mid-CALL SHALL return downSignal to 1 on the same edge and discard the call without a callValid pulse.

Configuration
REQ-020 Macro SBQM_CALL_TIMEOUT_EN defined: each pending bit SHALL have an age counter that counts only while emptyFlag==1 and clears when its teller is granted or re-requests. At TIMEOUT_CYCLES the pending bit SHALL clear silently.
REQ-021 Macro SBQM_CALL_TIMEOUT_EN undefined: pending bits SHALL persist indefinitely; no age counters shall exist.

Verification
REQ-022 Reset, then tellerReady[0] 0->1 with Tcount=3 and emptyFlag=0 -> downSignal low for 2 cycles, callValid at cycle 3, servingTeller=0, ticketNum=1.
REQ-023 Rises on tellers 0,1,2,3 in the same cycle -> four calls in order 0,1,2,3, spaced 5 cycles apart; ticketNum ends at 4.
REQ-024 Nine calls in total -> ticketNum wraps 7->0->1.
REQ-025 Tcount=1 and a rise on teller 3 -> no call; busy stays 0.
REQ-026 emptyFlag=1 and a rise on teller 2 -> no pulse; after emptyFlag drops, one call. With SBQM_CALL_TIMEOUT_EN and emptyFlag held 1 for 64 cycles -> request dropped, no call.
REQ-027 Reset asserted in the 2nd CALL cycle -> downSignal=1 on the next edge, no callValid, ticketNum=0.

Source files
------------

// File: rtl/sbqm_teller_caller.sv
// Teller caller: detects teller call requests, grants them round-robin and drives the queue departure pulse.
// Optional macro SBQM_CALL_TIMEOUT_EN drops requests that stay pending too long while the queue is empty.
module sbqm_teller_caller #(
    parameter int unsigned PULSE_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] tellerReady,
    input  logic [1:0] Tcount,
    input  logic       emptyFlag,
    output logic       downSignal,
    output logic [1:0] servingTeller,
    output logic [2:0] ticketNum,
    output logic       callValid,
    output logic       busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_CALL, S_GAP} state_t;

    if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("sbqm_teller_caller: illegal PULSE_CYCLES or TIMEOUT_CYCLES");
    end

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_prev, r_pending, w_pending_nxt;
    logic [1:0]       r_last, w_last_nxt, r_grant, w_grant_nxt;
    logic             r_down, w_down_nxt;
    logic [1:0]       r_serving, w_serving_nxt;
    logic [2:0]       r_ticket, w_ticket_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_busy;
    logic [3:0]       w_rise, w_elig, w_req, w_clr, w_tmo;
    logic             w_found;
    logic [1:0]       w_gidx;

    assign w_rise = tellerReady & ~r_prev;
    assign w_req  = r_pending & w_elig;

    // Eligibility mask and round-robin search starting after the last grant
    always_comb begin
        w_elig  = '0;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int i = 0; i < 4; i++) begin
            w_elig[i] = (2'(i) <= Tcount);
        end
        for (int k = 0; k < 4; k++) begin
            if (!w_found && w_req[2'(r_last + 2'(k + 1))]) begin
                w_found = 1'b1;
                w_gidx  = 2'(r_last + 2'(k + 1));
            end
        end
    end

`ifdef SBQM_CALL_TIMEOUT_EN
    localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [AGE_W-1:0] r_age [4];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset || !r_pending[i] || w_clr[i] || w_rise[i]) begin
                r_age[i] <= '0;
            end else if (emptyFlag) begin
                r_age[i] <= r_age[i] + AGE_W'(1);
            end
        end
    end

    always_comb begin
        w_tmo = '0;
        for (int i = 0; i < 4; i++) begin
            w_tmo[i] = r_pending[i] & emptyFlag & ~w_rise[i] &
                       (r_age[i] == AGE_W'(TIMEOUT_CYCLES - 1));
        end
    end
`else
    assign w_tmo = '0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_down_nxt    = 1'b1;
        w_valid_nxt   = 1'b0;
        w_serving_nxt = r_serving;
        w_ticket_nxt  = r_ticket;
        w_last_nxt    = r_last;
        w_grant_nxt   = r_grant;
        w_clr         = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !emptyFlag) begin
                    w_state_nxt   = S_CALL;
                    w_cnt_nxt     = '0;
                    w_down_nxt    = 1'b0;
                    w_grant_nxt   = w_gidx;
                    w_last_nxt    = w_gidx;
                    w_clr[w_gidx] = 1'b1;
                end
            end
            S_CALL: begin
                w_down_nxt = 1'b0;
                if (r_cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    w_state_nxt   = S_GAP;
                    w_cnt_nxt     = '0;
                    w_down_nxt    = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_serving_nxt = r_grant;
                    w_ticket_nxt  = r_ticket + 3'd1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A new rise beats a same-cycle grant clear or timeout
        w_pending_nxt = ((r_pending & ~w_clr & ~w_tmo) | w_rise) & w_elig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_prev    <= '0;
            r_pending <= '0;
            r_last    <= 2'd3;
            r_grant   <= '0;
            r_down    <= 1'b1;
            r_serving <= '0;
            r_ticket  <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_prev    <= tellerReady;
            r_pending <= w_pending_nxt;
            r_last    <= w_last_nxt;
            r_grant   <= w_grant_nxt;
            r_down    <= w_down_nxt;
            r_serving <= w_serving_nxt;
            r_ticket  <= w_ticket_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    assign downSignal    = r_down;
    assign servingTeller = r_serving;
    assign ticketNum     = r_ticket;
    assign callValid     = r_valid;
    assign busy          = r_busy;

endmodule
